// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WAIT, ST_ACK} arb_state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int LAT_CNT_W   = 4;

  function automatic bit mem_lat_legal(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// rtl/mem_port_arbiter_lat_counter.sv - load/decrement latency down-counter with terminal flag
module mem_lat_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int W = LAT_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_terminal
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Terminal on 1, not 0: the last wait cycle is the one that samples memory.
  assign o_terminal = (r_count == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory between fetch and data stages
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (!mem_lat_legal(MEM_LAT)) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be 1..15");
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT);

  arb_state_t r_state, w_next_state;
  owner_t     r_owner;
  logic       r_we;
  logic       r_cancel;
  logic       w_grant_d, w_grant_f;
  logic       w_cnt_load, w_cnt_dec, w_cnt_term;
  logic       w_done, w_drop;

  mem_lat_counter #(.W(LAT_CNT_W)) u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (LAT_LOAD),
    .i_dec      (w_cnt_dec),
    .o_terminal (w_cnt_term)
  );

  // A flush arriving in the final wait cycle still cancels the fetch response.
  assign w_drop = (r_owner == OWN_FETCH) && (r_cancel || if_flush);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_d    = 1'b0;
    w_grant_f    = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (d_req) begin
          w_grant_d    = 1'b1;
          w_next_state = ST_CMD;
        end else if (if_req && !if_flush) begin
          w_grant_f    = 1'b1;
          w_next_state = ST_CMD;
        end
      end
      ST_CMD: begin
        w_cnt_load   = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_term) begin
          w_done       = 1'b1;
          w_next_state = w_drop ? ST_IDLE : ST_ACK;
        end
      end
      ST_ACK:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_owner   <= OWN_FETCH;
      r_we      <= 1'b0;
      r_cancel  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (w_grant_d) begin
        r_owner   <= OWN_DATA;
        r_we      <= d_we;
        r_cancel  <= 1'b0;
        mem_en    <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (w_grant_f) begin
        r_owner  <= OWN_FETCH;
        r_we     <= 1'b0;
        r_cancel <= 1'b0;
        mem_en   <= 1'b1;
        mem_addr <= if_addr;
      end
      if ((r_state == ST_CMD || r_state == ST_WAIT) && r_owner == OWN_FETCH && if_flush) begin
        r_cancel <= 1'b1;
      end
      if (w_done) begin
        if (r_owner == OWN_DATA) begin
          d_ack <= 1'b1;
          if (!r_we) d_rdata <= mem_rdata;
        end else if (!w_drop) begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, fixed-latency unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline. Accepts level-held requests from both stages and grants one access at a time, data stage first. Sequences the memory command and the latency wait, returns read data with a one-cycle acknowledge, and produces per-stage stall signals for the pipeline registers. Sits between Instr_Fetch/Data_memory and the physical memory macro.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch read request, held until if_ack
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_flush  in  1  jump/redirect; cancels the pending or in-flight fetch
- if_rdata  out  DATA_W  fetched instruction, valid with if_ack
- if_ack  out  1  one-cycle fetch completion
- if_stall  out  1  if_req & ~if_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_ack
- d_ack  out  1  one-cycle data completion
- d_stall  out  1  d_req & ~d_ack
- mem_en  out  1  one-cycle memory command strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, CMD, WAIT, ACK.
- IDLE: if d_req, latch d_we/d_addr/d_wdata, owner=DATA, go CMD; else if if_req & ~if_flush, latch if_addr, owner=FETCH, go CMD; else stay.
- Fixed priority: data over fetch. The MEM stage holds the older instruction, so fetch must never block it.
- CMD: mem_en=1, mem_we/mem_addr/mem_wdata from latched values; load counter with MEM_LAT; go WAIT.
- WAIT: decrement counter; when counter reaches 1, capture mem_rdata for reads, go ACK.
- ACK: assert the owner's ack for exactly one cycle; go IDLE. No grant is made in ACK, so the requester's still-high req is not re-accepted.
- Writes take the same sequence. d_rdata holds its previous value on a write ack.
- Flush: if_flush while owner=FETCH in CMD/WAIT sets a cancel flag. The access completes on memory, but if_ack is suppressed and if_rdata is not updated. if_flush in IDLE blocks a fetch grant that cycle. A flush has no effect on data accesses.
- if_stall and d_stall are combinational; all other outputs are registered.
- Reset (reset=0 at an edge): state=IDLE, counter=0, cancel=0. mem_en, mem_we, if_ack, d_ack are 0. mem_addr, mem_wdata, if_rdata, d_rdata are 0. A mid-access reset abandons the access and discards its response.

## Timing
- With a request seen in IDLE at cycle R: mem_en is high in R+1; mem_rdata is sampled at the end of R+1+MEM_LAT; ack is high in R+MEM_LAT+2.
- Back-to-back throughput is one access per MEM_LAT+3 cycles.
- When both requesters are waiting, the data access is served first and fetch is granted in the IDLE cycle after data's ACK.
- Requesters must deassert req, or change it to a new request, in the cycle after ack. A req still high in the ACK cycle is ignored.

## Structure
- A shared package holds the state enum (IDLE/CMD/WAIT/ACK), the owner enum (FETCH/DATA), and the MEM_LAT range-check constant.
- One sub-module, mem_lat_counter: a load/decrement down-counter with a terminal flag.

## Test plan
- Single read at reset-release, MEM_LAT=2, if_req, if_addr=0x40, mem_rdata=0x8C020004 -> mem_en at R+1, if_ack at R+4, if_rdata=0x8C020004.
- Simultaneous if_req and d_req (d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF) in the same cycle -> write issued first with d_ack at R+4. Fetch mem_en follows at R+6, if_ack at R+9. if_stall stays high throughout.
- if_flush pulsed during WAIT of a fetch -> mem_en still issued once, if_ack never asserted, FSM back in IDLE at R+4.
- reset=0 during WAIT of a data read -> all outputs 0 the next cycle. The late mem_rdata is ignored and no d_ack occurs.
- MEM_LAT=1 and MEM_LAT=15 sweep with continuous d_req -> ack spacing of 4 and 18 cycles, exactly one mem_en per ack.
- d_req held high through its ACK cycle -> no second mem_en until the IDLE cycle after ACK.
